// File: rtl/k005292_timing_tracker_if.sv
// Video timing bundle between a K005292-style timing source and the tracker.
// The master drives the pixel enable and blanking strobes and consumes the
// recovered coordinates and measurements. The slave is the tracker.
interface k005292_timing_tracker_if #(
  parameter int HCNT_W = 10,
  parameter int VCNT_W = 10
);
  logic              i_EMU_CLK6MPCEN_n;
  logic              i_HBLANK_n;
  logic              i_VBLANK_n;
  logic              i_VSYNC_n;
  logic [8:0]        o_HPOS;
  logic [8:0]        o_VPOS;
  logic              o_DE;
  logic              o_LINE_START;
  logic              o_FRAME_START;
  logic [HCNT_W-1:0] o_HTOTAL;
  logic [VCNT_W-1:0] o_VTOTAL;
  logic              o_LOCKED;

  modport master (
    output i_EMU_CLK6MPCEN_n, i_HBLANK_n, i_VBLANK_n, i_VSYNC_n,
    input  o_HPOS, o_VPOS, o_DE, o_LINE_START, o_FRAME_START,
           o_HTOTAL, o_VTOTAL, o_LOCKED
  );

  modport slave (
    input  i_EMU_CLK6MPCEN_n, i_HBLANK_n, i_VBLANK_n, i_VSYNC_n,
    output o_HPOS, o_VPOS, o_DE, o_LINE_START, o_FRAME_START,
           o_HTOTAL, o_VTOTAL, o_LOCKED
  );
endinterface

// File: rtl/k005292_timing_tracker.sv
// Receiving end of a K005292-style video timing interface.
// Samples the blanking/sync strobes on the pixel enable, recovers active-area
// pixel coordinates, measures line/frame lengths and reports timing lock.
//
// state   | meaning
// SEARCH  | no usable timing; waiting for a VSYNC fall to start measuring
// MEASURE | first frame records the reference, later frames count matches
// LOCKED  | LOCK_FRAMES consecutive matching frames seen; any mismatch drops
module k005292_timing_tracker #(
  parameter int LOCK_FRAMES = 2,
  parameter int HCNT_W      = 10,
  parameter int VCNT_W      = 10
) (
  input logic                     i_EMU_MCLK,
  input logic                     i_MRST,
  k005292_timing_tracker_if.slave vid
);

  localparam int CNT_W = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);
  localparam logic [HCNT_W-1:0] HMAX = '1;
  localparam logic [VCNT_W-1:0] VMAX = '1;
  localparam logic [8:0]        PMAX = '1;

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} lock_state_t;

  lock_state_t       state_q, state_d;
  logic              ref_valid_q, ref_valid_d;
  logic [CNT_W-1:0]  count_q, count_d, count_inc;
  logic              locked_q, locked_d;

  logic              hb_prev, vb_prev, vs_prev;
  logic              vb_line;
  logic              h_bad;
  logic [HCNT_W-1:0] hrun, htotal, hrun_inc;
  logic [VCNT_W-1:0] vrun, vtotal, vrun_inc, vtot_new;
  logic [8:0]        hpos, vpos;
  logic              de, line_start, frame_start;

  logic en, hrise, vsfall, h_mis, v_mis, h_sat;

  assign en       = ~vid.i_EMU_CLK6MPCEN_n;
  assign hrise    = en & vid.i_HBLANK_n & ~hb_prev;
  assign vsfall   = en & ~vid.i_VSYNC_n & vs_prev;
  assign hrun_inc = (hrun == HMAX) ? HMAX : hrun + 1'b1;
  assign vrun_inc = (vrun == VMAX) ? VMAX : vrun + 1'b1;
  // A VSYNC fall landing on a line start counts that line in the closing frame.
  assign vtot_new = hrise ? vrun_inc : vrun;
  assign h_mis    = hrise & (hrun != htotal);
  assign v_mis    = vsfall & (vtot_new != vtotal);
  // HBLANK lost: line counter about to pin at its ceiling.
  assign h_sat    = en & ~hrise & (hrun_inc == HMAX);

  // Previous samples for edge detection, only advanced on pixel enables.
  always_ff @(posedge i_EMU_MCLK or posedge i_MRST) begin
    if (i_MRST) begin
      hb_prev <= 1'b1;
      vb_prev <= 1'b1;
      vs_prev <= 1'b1;
    end else if (en) begin
      hb_prev <= vid.i_HBLANK_n;
      vb_prev <= vid.i_VBLANK_n;
      vs_prev <= vid.i_VSYNC_n;
    end
  end

  // Horizontal: line length measurement, active pixel index, data enable.
  always_ff @(posedge i_EMU_MCLK or posedge i_MRST) begin
    if (i_MRST) begin
      hrun       <= '0;
      htotal     <= '0;
      hpos       <= '0;
      de         <= 1'b0;
      line_start <= 1'b0;
    end else begin
      line_start <= 1'b0;
      if (en) begin
        de <= vid.i_HBLANK_n & vid.i_VBLANK_n;
        if (hrise) begin
          htotal     <= hrun;
          hrun       <= HCNT_W'(1);
          hpos       <= '0;
          line_start <= 1'b1;
        end else begin
          hrun <= hrun_inc;
          if (vid.i_HBLANK_n && hpos != PMAX) hpos <= hpos + 9'd1;
        end
      end
    end
  end

  // Vertical: active line index on line starts, frame length between VSYNC falls.
  // vb_line comes out of reset as "active" so a reset mid-frame cannot fake a
  // frame start before a blanked line has been seen.
  always_ff @(posedge i_EMU_MCLK or posedge i_MRST) begin
    if (i_MRST) begin
      vpos        <= '0;
      vb_line     <= 1'b1;
      frame_start <= 1'b0;
      vrun        <= '0;
      vtotal      <= '0;
    end else begin
      frame_start <= 1'b0;
      if (hrise) begin
        vb_line <= vid.i_VBLANK_n;
        if (vid.i_VBLANK_n && !vb_line) begin
          vpos        <= '0;
          frame_start <= 1'b1;
        end else if (vid.i_VBLANK_n && vpos != PMAX) begin
          vpos <= vpos + 9'd1;
        end
      end
      if (vsfall) begin
        vtotal <= vtot_new;
        vrun   <= '0;
      end else if (hrise) begin
        vrun <= vrun_inc;
      end
    end
  end

  // Any line of the current frame whose length differed from the previous one.
  always_ff @(posedge i_EMU_MCLK or posedge i_MRST) begin
    if (i_MRST) h_bad <= 1'b0;
    else if (vsfall) h_bad <= 1'b0;
    else if (h_mis) h_bad <= 1'b1;
  end

  // Lock FSM state register.
  always_ff @(posedge i_EMU_MCLK or posedge i_MRST) begin
    if (i_MRST) begin
      state_q     <= SEARCH;
      ref_valid_q <= 1'b0;
      count_q     <= '0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ref_valid_q <= ref_valid_d;
      count_q     <= count_d;
      locked_q    <= locked_d;
    end
  end

  // Lock FSM next state; a mismatch on the closing line still counts against the frame.
  always_comb begin
    state_d     = state_q;
    ref_valid_d = ref_valid_q;
    count_d     = count_q;
    locked_d    = locked_q;
    count_inc   = count_q + 1'b1;
    case (state_q)
      SEARCH: begin
        if (vsfall) begin
          state_d     = MEASURE;
          ref_valid_d = 1'b0;
          count_d     = '0;
        end
      end
      MEASURE: begin
        if (vsfall) begin
          if (!ref_valid_q) begin
            ref_valid_d = 1'b1;
          end else if (!v_mis && !(h_bad | h_mis)) begin
            count_d = count_inc;
            if (count_inc == CNT_W'(LOCK_FRAMES)) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
            end
          end else begin
            count_d = '0;
          end
        end
      end
      LOCKED: begin
        if (h_mis || v_mis) begin
          state_d  = SEARCH;
          locked_d = 1'b0;
        end
      end
      default: begin
        state_d  = SEARCH;
        locked_d = 1'b0;
      end
    endcase
    if (h_sat) begin
      state_d  = SEARCH;
      locked_d = 1'b0;
    end
  end

  assign vid.o_HPOS        = hpos;
  assign vid.o_VPOS        = vpos;
  assign vid.o_DE          = de;
  assign vid.o_LINE_START  = line_start;
  assign vid.o_FRAME_START = frame_start;
  assign vid.o_HTOTAL      = htotal;
  assign vid.o_VTOTAL      = vtotal;
  assign vid.o_LOCKED      = locked_q;

endmodule

// File: tb/tb_k005292_timing_tracker.sv
// Bench for k005292_timing_tracker on scaled-down K005292-style timing:
// 24 px/line (16 active), 20 lines/frame (14 active), VSYNC low for 2 lines.
module tb_k005292_timing_tracker;
  localparam int LINE  = 24;
  localparam int ACT   = 16;
  localparam int VACT  = 14;
  localparam int VS_L  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  k005292_timing_tracker_if #(.HCNT_W(10), .VCNT_W(10)) vid();

  k005292_timing_tracker #(.LOCK_FRAMES(2), .HCNT_W(10), .VCNT_W(10)) dut (
    .i_EMU_MCLK (clk),
    .i_MRST     (rst),
    .vid        (vid)
  );

  typedef struct {
    int   vpos;
    logic fs;
    int   ht;
    int   vt;
    logic lk;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_pulses = 0;
  int   prev_len = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input int vpos, input logic fs, input int ht, input int vt, input logic lk);
    exp_t e;
    e.vpos = vpos; e.fs = fs; e.ht = ht; e.vt = vt; e.lk = lk;
    exp_q.push_back(e);
  endtask

  // One pixel: enable low for one MCLK, then high for three.
  task automatic pix(input logic hb, input logic vb, input logic vs);
    @(negedge clk);
    vid.i_HBLANK_n        = hb;
    vid.i_VBLANK_n        = vb;
    vid.i_VSYNC_n         = vs;
    vid.i_EMU_CLK6MPCEN_n = 1'b0;
    @(negedge clk);
    vid.i_EMU_CLK6MPCEN_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // One frame. VSYNC falls on line VS_L at pixel voff; totals/lock switch
  // from the _pre to the _post values at that fall, and lock reads 0 from
  // drop_line's start onward until then.
  task automatic frame(input int nlines, input int short_line, input int drop_line,
                       input int voff, input int vt_pre, input logic lk_pre,
                       input int vt_post, input logic lk_post);
    for (int l = 0; l < nlines; l++) begin
      int   len;
      bit   post;
      logic vb;
      logic lk;
      len  = (l == short_line) ? LINE - 1 : LINE;
      post = (voff == 0) ? (l >= VS_L) : (l > VS_L);
      vb   = (l < VACT);
      lk   = post ? lk_post : ((l >= drop_line) ? 1'b0 : lk_pre);
      push_exp((l < VACT) ? l : VACT - 1, (l == 0), prev_len, post ? vt_post : vt_pre, lk);
      for (int p = 0; p < len; p++) begin
        logic vs;
        vs = !((l == VS_L && p >= voff) || l == VS_L + 1 || (l == VS_L + 2 && p < voff));
        pix(p < ACT, vb, vs);
        if (l == VACT - 1 && p == ACT - 1) begin
          check("hpos_last_active", vid.o_HPOS, ACT - 1);
          check("vpos_last_active", vid.o_VPOS, VACT - 1);
          check("de_active", vid.o_DE, 1);
        end
        if (l == VACT - 1 && p == ACT) begin
          check("de_blank", vid.o_DE, 0);
          check("hpos_hold_blank", vid.o_HPOS, ACT - 1);
        end
      end
      prev_len = len;
    end
  endtask

  // Scoreboard monitor: pops one expectation per line-start pulse.
  logic ls_prev = 1'b0;
  logic fs_prev = 1'b0;
  always @(negedge clk) begin : mon
    exp_t e;
    if (ls_prev) check("line_start_width", vid.o_LINE_START, 0);
    if (fs_prev) check("frame_start_width", vid.o_FRAME_START, 0);
    if (vid.o_LINE_START === 1'b1) begin
      n_checks++;
      n_pulses++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL line_start_unexpected #%0d: got a pulse, expected none", n_pulses);
      end else begin
        e = exp_q.pop_front();
        if (vid.o_HPOS !== 9'd0 || vid.o_VPOS !== 9'(e.vpos) || vid.o_FRAME_START !== e.fs ||
            vid.o_HTOTAL !== 10'(e.ht) || vid.o_VTOTAL !== 10'(e.vt) || vid.o_LOCKED !== e.lk) begin
          n_errors++;
          $display("FAIL line_start_state #%0d: got hpos=%0d vpos=%0d fs=%0b ht=%0d vt=%0d lk=%0b, expected hpos=0 vpos=%0d fs=%0b ht=%0d vt=%0d lk=%0b",
                   n_pulses, vid.o_HPOS, vid.o_VPOS, vid.o_FRAME_START, vid.o_HTOTAL,
                   vid.o_VTOTAL, vid.o_LOCKED, e.vpos, e.fs, e.ht, e.vt, e.lk);
        end
      end
    end else if (vid.o_FRAME_START === 1'b1) begin
      check("frame_start_alone", vid.o_FRAME_START, 0);
    end
    ls_prev = vid.o_LINE_START;
    fs_prev = vid.o_FRAME_START;
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_hpos"}, vid.o_HPOS, 0);
    check({tag, "_vpos"}, vid.o_VPOS, 0);
    check({tag, "_de"}, vid.o_DE, 0);
    check({tag, "_line_start"}, vid.o_LINE_START, 0);
    check({tag, "_frame_start"}, vid.o_FRAME_START, 0);
    check({tag, "_htotal"}, vid.o_HTOTAL, 0);
    check({tag, "_vtotal"}, vid.o_VTOTAL, 0);
    check({tag, "_locked"}, vid.o_LOCKED, 0);
  endtask

  initial begin
    vid.i_EMU_CLK6MPCEN_n = 1'b1;
    vid.i_HBLANK_n        = 1'b0;
    vid.i_VBLANK_n        = 1'b0;
    vid.i_VSYNC_n         = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Preamble in vertical blank: 8 blank pixels, then one full blanked line.
    repeat (8) pix(1'b0, 1'b0, 1'b1);
    push_exp(0, 1'b0, 8, 0, 1'b0);
    for (int p = 0; p < LINE; p++) pix(p < ACT, 1'b0, 1'b1);
    prev_len = LINE;

    // Acquisition: MEASURE, reference, one match, lock on the 4th VSYNC fall.
    frame(20, -1, 999, 12,  0, 1'b0, 18, 1'b0);
    frame(20, -1, 999, 12, 18, 1'b0, 20, 1'b0);
    frame(20, -1, 999, 12, 20, 1'b0, 20, 1'b0);
    frame(20, -1, 999, 12, 20, 1'b0, 20, 1'b1);

    // One 23-pixel line: lock drops at the start of the following line.
    frame(20, 5, 6, 12, 20, 1'b1, 20, 1'b0);
    frame(20, -1, 999, 12, 20, 1'b0, 20, 1'b0);
    frame(20, -1, 999, 12, 20, 1'b0, 20, 1'b0);
    frame(20, -1, 999, 12, 20, 1'b0, 20, 1'b1);

    // 19-line frame, measured at the next VSYNC fall, which lands on a line start.
    frame(19, -1, 999, 12, 20, 1'b1, 20, 1'b1);
    frame(20, -1, 999,  0, 20, 1'b1, 19, 1'b0);
    frame(20, -1, 999,  0, 19, 1'b0, 20, 1'b0);
    frame(20, -1, 999,  0, 20, 1'b0, 20, 1'b0);
    frame(20, -1, 999,  0, 20, 1'b0, 20, 1'b0);
    frame(20, -1, 999,  0, 20, 1'b0, 20, 1'b1);

    // HBLANK held low: line counter runs from 24 to its 1023 ceiling.
    for (int k = 0; k < 998; k++) pix(1'b0, 1'b0, 1'b1);
    check("locked_before_sat", vid.o_LOCKED, 1);
    pix(1'b0, 1'b0, 1'b1);
    check("locked_at_sat", vid.o_LOCKED, 0);
    check("hpos_frozen_sat", vid.o_HPOS, ACT - 1);
    check("htotal_kept_sat", vid.o_HTOTAL, LINE);
    repeat (4) pix(1'b0, 1'b0, 1'b1);
    check("locked_after_sat", vid.o_LOCKED, 0);

    // Line start after saturation, then reset while that pulse is high.
    push_exp(VACT - 1, 1'b0, 1023, 20, 1'b0);
    @(negedge clk);
    vid.i_HBLANK_n        = 1'b1;
    vid.i_EMU_CLK6MPCEN_n = 1'b0;
    @(negedge clk);
    vid.i_EMU_CLK6MPCEN_n = 1'b1;
    #1 rst = 1'b1;
    #1 check_all_zero("async_reset");
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      vid.i_EMU_CLK6MPCEN_n = ~vid.i_EMU_CLK6MPCEN_n;
    end
    @(negedge clk);
    vid.i_EMU_CLK6MPCEN_n = 1'b1;
    check_all_zero("reset_held");
    rst = 1'b0;

    // HBLANK_n already high at the first enable: no line start may appear.
    pix(1'b1, 1'b0, 1'b1);
    check("no_false_hrise", vid.o_LINE_START, 0);
    check("htotal_after_release", vid.o_HTOTAL, 0);
    repeat (3) pix(1'b0, 1'b0, 1'b1);
    push_exp(0, 1'b0, 4, 0, 1'b0);
    pix(1'b1, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    check("expectations_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
